// File: rtl/uart_alu_ctrl_pkg.sv
// rtl/uart_alu_ctrl_pkg.sv - shared state encoding and default widths for uart_alu_ctrl
package uart_alu_ctrl_pkg;

  localparam int DEF_SIZEDATA = 8;
  localparam int DEF_SIZEOP   = 6;

  typedef enum logic [2:0] {
    ST_WAIT_A  = 3'd0,
    ST_WAIT_B  = 3'd1,
    ST_WAIT_OP = 3'd2,
    ST_COMPUTE = 3'd3,
    ST_SEND    = 3'd4,
    ST_WAIT_TX = 3'd5
  } state_t;

  // Received bytes are refused while a result is being produced or sent.
  function automatic logic is_busy(input state_t s);
    return (s == ST_COMPUTE) || (s == ST_SEND) || (s == ST_WAIT_TX);
  endfunction

endpackage

// File: rtl/uart_alu_timeout.sv
// rtl/uart_alu_timeout.sv - inter-byte timeout counter; expired flags the last idle cycle
module uart_alu_timeout #(
  parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
  input  logic i_clock,
  input  logic i_reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES);

  logic [CW-1:0] count;

  // Counter sits at zero whenever disabled, so every wait starts from a full budget.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      count <= '0;
    end else if (clear || !enable) begin
      count <= '0;
    end else begin
      count <= count + CW'(1);
    end
  end

  assign expired = enable && (count == CW'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/uart_alu_ctrl.sv
// rtl/uart_alu_ctrl.sv - UART-fed ALU frame controller (A, B, opcode -> result byte)
// Optional inter-byte timeout enabled by defining UART_ALU_CTRL_TIMEOUT_EN.
module uart_alu_ctrl
  import uart_alu_ctrl_pkg::*;
#(
  parameter int          SIZEDATA       = DEF_SIZEDATA,
  parameter int          SIZEOP         = DEF_SIZEOP,
  parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
  input  logic                i_clock,
  input  logic                i_reset,
  input  logic                i_rx_done,
  input  logic [SIZEDATA-1:0] i_rx_data,
  input  logic [SIZEDATA-1:0] i_alu_result,
  input  logic                i_tx_done,
  output logic [SIZEDATA-1:0] o_alu_datoa,
  output logic [SIZEDATA-1:0] o_alu_datob,
  output logic [SIZEOP-1:0]   o_alu_opcode,
  output logic [SIZEDATA-1:0] o_tx_data,
  output logic                o_tx_start,
  output logic                o_busy,
  output logic                o_drop,
  output logic                o_timeout
);

  if ((SIZEOP < 1) || (SIZEOP > SIZEDATA) || (TIMEOUT_CYCLES < 2)) begin : g_bad_cfg
    $error("uart_alu_ctrl: invalid SIZEOP/SIZEDATA/TIMEOUT_CYCLES");
  end

  state_t state, state_next;
  logic   timeout_expired;

`ifdef UART_ALU_CTRL_TIMEOUT_EN
  logic timeout_enable;

  assign timeout_enable = (state == ST_WAIT_B) || (state == ST_WAIT_OP);

  // Any i_rx_done in the counting states is an accepted byte, so it restarts the count.
  uart_alu_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .i_clock (i_clock),
    .i_reset (i_reset),
    .clear   (i_rx_done),
    .enable  (timeout_enable),
    .expired (timeout_expired)
  );
`else
  assign timeout_expired = 1'b0;
`endif

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      state <= ST_WAIT_A;
    end else begin
      state <= state_next;
    end
  end

  // A byte arriving on the expiry cycle wins over the timeout.
  always_comb begin
    state_next = state;
    case (state)
      ST_WAIT_A:  if (i_rx_done) state_next = ST_WAIT_B;
      ST_WAIT_B: begin
        if (i_rx_done)            state_next = ST_WAIT_OP;
        else if (timeout_expired) state_next = ST_WAIT_A;
      end
      ST_WAIT_OP: begin
        if (i_rx_done)            state_next = ST_COMPUTE;
        else if (timeout_expired) state_next = ST_WAIT_A;
      end
      ST_COMPUTE: state_next = ST_SEND;
      ST_SEND:    state_next = ST_WAIT_TX;
      ST_WAIT_TX: if (i_tx_done) state_next = ST_WAIT_A;
      default:    state_next = ST_WAIT_A;
    endcase
  end

  always_comb begin
    o_busy     = is_busy(state);
    o_tx_start = (state == ST_SEND);
    o_drop     = i_rx_done && o_busy;
    o_timeout  = timeout_expired && !i_rx_done;
  end

  // Captures only happen in the WAIT_* states, so dropped bytes never touch these registers.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      o_alu_datoa  <= '0;
      o_alu_datob  <= '0;
      o_alu_opcode <= '0;
      o_tx_data    <= '0;
    end else begin
      case (state)
        ST_WAIT_A:  if (i_rx_done) o_alu_datoa  <= i_rx_data;
        ST_WAIT_B:  if (i_rx_done) o_alu_datob  <= i_rx_data;
        ST_WAIT_OP: if (i_rx_done) o_alu_opcode <= i_rx_data[SIZEOP-1:0];
        ST_COMPUTE: o_tx_data <= i_alu_result;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_alu_ctrl.sv
// tb/tb_uart_alu_ctrl.sv - self-checking bench for uart_alu_ctrl against a frame-level reference model
module tb_uart_alu_ctrl;

  logic       i_clock = 1'b0;
  logic       i_reset;
  logic       i_rx_done;
  logic [7:0] i_rx_data;
  logic [7:0] i_alu_result;
  logic       i_tx_done;
  logic [7:0] o_alu_datoa;
  logic [7:0] o_alu_datob;
  logic [5:0] o_alu_opcode;
  logic [7:0] o_tx_data;
  logic       o_tx_start;
  logic       o_busy;
  logic       o_drop;
  logic       o_timeout;

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0] m_a, m_b, m_tx;
  logic [5:0] m_op;
  logic       d, t, flag;
  logic [5:0] ops [5] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h3f};

  uart_alu_ctrl #(
    .SIZEDATA(8),
    .SIZEOP(6),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .i_clock      (i_clock),
    .i_reset      (i_reset),
    .i_rx_done    (i_rx_done),
    .i_rx_data    (i_rx_data),
    .i_alu_result (i_alu_result),
    .i_tx_done    (i_tx_done),
    .o_alu_datoa  (o_alu_datoa),
    .o_alu_datob  (o_alu_datob),
    .o_alu_opcode (o_alu_opcode),
    .o_tx_data    (o_tx_data),
    .o_tx_start   (o_tx_start),
    .o_busy       (o_busy),
    .o_drop       (o_drop),
    .o_timeout    (o_timeout)
  );

  always #5 i_clock = ~i_clock;

  function automatic logic [7:0] alu_ref(input logic [7:0] a, input logic [7:0] b, input logic [5:0] op);
    case (op)
      6'h20:   return a + b;
      6'h22:   return a - b;
      6'h24:   return a & b;
      6'h25:   return a | b;
      default: return a ^ b;
    endcase
  endfunction

  assign i_alu_result = alu_ref(o_alu_datoa, o_alu_datob, o_alu_opcode);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic rx_byte(input logic [7:0] b, output logic drop, output logic to);
    @(negedge i_clock);
    i_rx_data = b;
    i_rx_done = 1'b1;
    #1;
    drop = o_drop;
    to   = o_timeout;
    @(posedge i_clock);
    #1 i_rx_done = 1'b0;
  endtask

  task automatic rx_with_tx_done(input logic [7:0] b, output logic drop);
    @(negedge i_clock);
    i_rx_data = b;
    i_rx_done = 1'b1;
    i_tx_done = 1'b1;
    #1 drop = o_drop;
    @(posedge i_clock);
    #1;
    i_rx_done = 1'b0;
    i_tx_done = 1'b0;
  endtask

  task automatic check_result(input string tag);
    @(negedge i_clock);
    chk({tag, " compute busy/start"}, {o_busy, o_tx_start}, 2'b10);
    @(negedge i_clock);
    chk({tag, " send busy/start"}, {o_busy, o_tx_start}, 2'b11);
    chk({tag, " tx_data"}, o_tx_data, m_tx);
    @(negedge i_clock);
    chk({tag, " wait_tx busy/start"}, {o_busy, o_tx_start}, 2'b10);
    chk({tag, " operands"}, {o_alu_datoa, o_alu_datob, 2'b00, o_alu_opcode}, {m_a, m_b, 2'b00, m_op});
  endtask

  task automatic run_frame(input logic [7:0] a, input logic [7:0] b, input logic [7:0] opb, input string tag);
    logic d0, d1, d2, tt;
    rx_byte(a, d0, tt);
    rx_byte(b, d1, tt);
    rx_byte(opb, d2, tt);
    m_a  = a;
    m_b  = b;
    m_op = opb[5:0];
    m_tx = alu_ref(m_a, m_b, m_op);
    chk({tag, " no drop"}, {d0, d1, d2}, 3'b000);
    check_result(tag);
  endtask

  task automatic finish_tx(input string tag);
    @(negedge i_clock);
    i_tx_done = 1'b1;
    @(posedge i_clock);
    #1 i_tx_done = 1'b0;
    @(negedge i_clock);
    chk({tag, " idle after tx_done"}, {o_busy, o_tx_start}, 2'b00);
  endtask

  initial begin
    i_reset   = 1'b1;
    i_rx_done = 1'b0;
    i_rx_data = 8'h00;
    i_tx_done = 1'b0;
    m_a = 8'h00; m_b = 8'h00; m_op = 6'h00; m_tx = 8'h00;

    repeat (3) @(posedge i_clock);
    @(negedge i_clock);
    chk("reset regs", {o_alu_datoa, o_alu_datob, 2'b00, o_alu_opcode, o_tx_data}, 32'h0);
    chk("reset flags", {o_tx_start, o_busy, o_drop, o_timeout}, 4'b0000);
    i_reset = 1'b0;

    run_frame(8'h05, 8'h03, 8'h20, "basic");
    chk("basic tx_data const", o_tx_data, 8'h08);
    finish_tx("basic");

    for (int i = 0; i < 6; i++) begin
      run_frame(8'($urandom), 8'($urandom), {2'($urandom_range(0, 3)), ops[$urandom_range(0, 4)]}, "random");
      finish_tx("random");
    end

    // tx_done outside WAIT_TX must not disturb anything
    @(negedge i_clock);
    i_tx_done = 1'b1;
    @(posedge i_clock);
    #1 i_tx_done = 1'b0;
    @(negedge i_clock);
    chk("stray tx_done state", {o_busy, o_tx_start}, 2'b00);
    run_frame(8'h10, 8'h22, 8'hE2, "after stray tx_done");
    finish_tx("after stray tx_done");

    // byte arriving while waiting on the transmitter
    run_frame(8'($urandom), 8'($urandom), 8'h24, "drop frame");
    rx_byte(8'h77, d, t);
    chk("drop in wait_tx", d, 1'b1);
    @(negedge i_clock);
    chk("drop single pulse", o_drop, 1'b0);
    chk("drop keeps operands", {o_alu_datoa, o_alu_datob, 2'b00, o_alu_opcode}, {m_a, m_b, 2'b00, m_op});
    chk("drop keeps wait_tx", {o_busy, o_tx_start}, 2'b10);
    finish_tx("drop frame");
    run_frame(8'h40, 8'h01, 8'h22, "post drop");
    finish_tx("post drop");

    // rx and tx_done together in WAIT_TX
    run_frame(8'hA5, 8'h5A, 8'h25, "coincident");
    rx_with_tx_done(8'h77, d);
    chk("coincident drop", d, 1'b1);
    @(negedge i_clock);
    chk("coincident to wait_a", o_busy, 1'b0);
    chk("coincident A not captured", o_alu_datoa, m_a);
    run_frame(8'h33, 8'h44, 8'h3f, "post coincident");
    finish_tx("post coincident");

`ifdef UART_ALU_CTRL_TIMEOUT_EN
    rx_byte(8'h05, d, t);
    m_a = 8'h05;
    flag = 1'b0;
    for (int i = 1; i <= 16; i++) begin
      @(negedge i_clock);
      if (i < 16) flag = flag | o_timeout;
      else        chk("timeout pulse", o_timeout, 1'b1);
    end
    chk("timeout not early", flag, 1'b0);
    @(negedge i_clock);
    chk("timeout single pulse/idle", {o_timeout, o_busy}, 2'b00);
    chk("timeout keeps A", o_alu_datoa, m_a);
    run_frame(8'h01, 8'h02, 8'h20, "after timeout");
    chk("after timeout tx const", o_tx_data, 8'h03);
    finish_tx("after timeout");

    // byte on the expiry cycle wins
    rx_byte(8'h11, d, t);
    repeat (15) @(negedge i_clock);
    rx_byte(8'h22, d, t);
    chk("expiry byte no timeout", t, 1'b0);
    rx_byte(8'h20, d, t);
    m_a = 8'h11; m_b = 8'h22; m_op = 6'h20; m_tx = 8'h33;
    check_result("expiry race");
    finish_tx("expiry race");
`else
    rx_byte(8'h05, d, t);
    flag = 1'b0;
    for (int i = 0; i < 10000; i++) begin
      @(negedge i_clock);
      flag = flag | o_timeout | o_busy;
    end
    chk("no timeout when disabled", flag, 1'b0);
    rx_byte(8'h03, d, t);
    rx_byte(8'h20, d, t);
    m_a = 8'h05; m_b = 8'h03; m_op = 6'h20; m_tx = 8'h08;
    check_result("late frame");
    finish_tx("late frame");
`endif

    // reset in WAIT_OP abandons the frame
    rx_byte(8'h05, d, t);
    rx_byte(8'h03, d, t);
    @(posedge i_clock);
    #2 i_reset = 1'b1;
    #1;
    chk("midframe reset regs", {o_alu_datoa, o_alu_datob, 2'b00, o_alu_opcode, o_tx_data}, 32'h0);
    chk("midframe reset flags", {o_tx_start, o_busy, o_drop, o_timeout}, 4'b0000);
    @(negedge i_clock);
    i_reset = 1'b0;
    flag = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge i_clock);
      flag = flag | o_tx_start | o_busy;
    end
    chk("no tx_start after reset", flag, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
